sub_pipe_param: RTL
===================

Name: sub_pipe_param

Overview:
- Parametrised, pipelined add/subtract unit that supersedes the fixed 4-bit, fixed-latency subtract-and-delay block.
- Takes two unsigned WIDTH-bit operands and produces a signed WIDTH+1-bit result after a programmable delay.
- Carries a valid/ready handshake on both sides with full-pipeline stall under output backpressure, and supports a synchronous flush.
- Sits between operand-producing datapath stages and downstream consumers that can stall.

Parameters:
- WIDTH, 4: operand width in bits; must be >= 1.
- DELAY, 2: number of extra delay stages after the compute stage; must be >= 0.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous flush; drops all in-flight results.
- op_sub  input  1  1 = a-b, 0 = a+b; sampled together with the operands.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  unit can accept operands this cycle.
- a_in  input  WIDTH  operand A, unsigned.
- b_in  input  WIDTH  operand B, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- res_out  output  WIDTH+1  signed result.

Behaviour:
- Pipeline: input register stage (operands, op_sub, valid bit), then compute stage, then DELAY delay stages. Every stage carries its own valid bit.
- Latency: LAT = DELAY+2 cycles. A pair accepted on edge N appears on res_out/out_valid after edge N+LAT-1 when no stall occurs. Default LAT is 4.
- Advance: adv = !out_valid || out_ready. When adv is 1, every stage shifts forward one position. When adv is 0, every stage, including its valid bit, holds. Bubbles are not collapsed.
- Acceptance: in_ready = adv && !clr. A transfer occurs when in_valid && in_ready. If in_valid is low during an advance, a bubble (valid=0) enters the pipeline.
- Output transfer occurs when out_valid && out_ready. While out_valid is 1 and out_ready is 0, res_out is held stable.
- Arithmetic:
  - Operands are zero-extended to WIDTH+2 bits and the add or subtract is done at that width.
  - Subtract range is -(2^WIDTH-1) to 2^WIDTH-1 and always fits WIDTH+1 signed bits.
  - Add can reach 2^(WIDTH+1)-2 and therefore can exceed the WIDTH+1 signed range. Overflow handling depends on the optional feature.
- Data registers of invalid stages may hold any value; res_out is don't-care while out_valid is 0.
- clr: on the edge where clr=1, all valid bits clear, regardless of stall. The operands on that cycle are not accepted because in_ready is 0. out_valid is 0 on the following cycle.
- Reset: while rst_n is low, all valid bits and all data registers are 0, so out_valid=0 and res_out=0. in_ready is 1 while reset is asserted, provided clr=0. Reset asserted mid-operation discards all in-flight results immediately (asynchronously). The first acceptance after reset is the first rising edge with rst_n high.
- Throughput: one result per cycle while out_ready is held at 1.

Optional Feature:
- Macro: SUB_PIPE_SAT_EN.
- Defined: the compute stage saturates the WIDTH+2-bit result into the WIDTH+1-bit signed range (max 2^WIDTH-1, min -2^WIDTH). With WIDTH=4, 15+15 yields 15.
- Undefined: the result is truncated to the low WIDTH+1 bits, i.e. wraps two's-complement. With WIDTH=4, 15+15=30 yields 5'b11110 = -2.
- Subtract results are identical in both builds.

Test Plan:
- Defaults, out_ready=1, single pair a=3, b=9, op_sub=1 accepted at edge 0 -> out_valid=1 after edge 3 with res_out=-6 (5'b11010); out_valid=0 again on the next cycle.
- Back-to-back stream a=15/b=0, a=0/b=15, a=7/b=7, all subtract -> results 15, -15, 0 on three consecutive cycles; in_ready stays 1 throughout.
- out_ready=0 while a result is at the output -> in_ready=0, res_out and out_valid held for 5 cycles; on out_ready=1 the results drain in order, none lost and none duplicated.
- Add 15+15 with WIDTH=4 -> res_out=-2 without SUB_PIPE_SAT_EN and 15 with it; add 8+4 -> 12 in both builds.
- Three pairs in flight, clr pulsed for 1 cycle, also during a stall -> no out_valid for any of the three pairs; a new pair presented after the clr cycle emerges 4 cycles after its acceptance.
- rst_n asserted asynchronously mid-stream -> out_valid and res_out go to 0 without waiting for a clock edge; after release, a=1/b=2 subtract yields -1 after 4 cycles. Repeat with WIDTH=8, DELAY=0: 200-55 gives 145 after 2 cycles.

Source files
------------

// File: rtl/sub_pipe_param.sv
// sub_pipe_param: pipelined unsigned add/subtract with valid/ready handshake, stall and flush.
// Define SUB_PIPE_SAT_EN to saturate add overflow instead of wrapping it.
module sub_pipe_param #(
  parameter int WIDTH = 4,
  parameter int DELAY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  op_sub,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      a_in,
  input  logic [WIDTH-1:0]      b_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [WIDTH:0] res_out
);

`ifdef SUB_PIPE_SAT_EN
  localparam logic signed [WIDTH+1:0] SAT_MAX = {2'b00, {WIDTH{1'b1}}};
  localparam logic signed [WIDTH+1:0] SAT_MIN = {2'b11, {WIDTH{1'b0}}};
`endif

  logic [WIDTH-1:0]      r_a_p0;
  logic [WIDTH-1:0]      r_b_p0;
  logic                  r_op_p0;
  logic                  r_vld_p0;
  // Index 0 is the compute stage, indices 1..DELAY are the delay stages.
  logic signed [WIDTH:0] r_res_p1 [DELAY+1];
  logic [DELAY:0]        r_vld_p1;
  logic                  w_adv;
  logic signed [WIDTH+1:0] w_sum;

  // Narrow the extended-width result into the output range.
  function automatic logic signed [WIDTH:0] fit_res(input logic signed [WIDTH+1:0] x);
`ifdef SUB_PIPE_SAT_EN
    if (x > SAT_MAX) return (WIDTH+1)'(SAT_MAX);
    if (x < SAT_MIN) return (WIDTH+1)'(SAT_MIN);
`endif
    return (WIDTH+1)'(x);
  endfunction

  assign w_adv     = !out_valid || out_ready;
  assign in_ready  = w_adv && !clr;
  assign out_valid = r_vld_p1[DELAY];
  assign res_out   = r_res_p1[DELAY];

  assign w_sum = r_op_p0 ? ({2'b00, r_a_p0} - {2'b00, r_b_p0})
                         : ({2'b00, r_a_p0} + {2'b00, r_b_p0});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_p0   <= '0;
      r_b_p0   <= '0;
      r_op_p0  <= 1'b0;
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= '0;
      for (int i = 0; i <= DELAY; i++) r_res_p1[i] <= '0;
    end else begin
      if (w_adv) begin
        // p0: input register
        r_a_p0  <= a_in;
        r_b_p0  <= b_in;
        r_op_p0 <= op_sub;
        // p1[0]: compute, p1[1..DELAY]: delay line
        r_res_p1[0] <= fit_res(w_sum);
        for (int i = 1; i <= DELAY; i++) r_res_p1[i] <= r_res_p1[i-1];
      end
      if (clr) begin
        r_vld_p0 <= 1'b0;
        r_vld_p1 <= '0;
      end else if (w_adv) begin
        r_vld_p0    <= in_valid;
        r_vld_p1[0] <= r_vld_p0;
        for (int i = 1; i <= DELAY; i++) r_vld_p1[i] <= r_vld_p1[i-1];
      end
    end
  end

endmodule
